// File: rtl/subtractor_serial_16bit.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_serial_16bit
// Description : Bit-serial subtractor, diff = a - b - borrow_in, LSB first,
//               with a start/busy/done handshake and held results.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_serial_16bit #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 underflow
);

    localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(BIT_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,   w_cnt_d;
    logic [BIT_WIDTH-1:0]  r_a_q,     w_a_d;
    logic [BIT_WIDTH-1:0]  r_b_q,     w_b_d;
    logic [BIT_WIDTH-1:0]  r_res_q,   w_res_d;
    logic [BIT_WIDTH-1:0]  r_diff_q,  w_diff_d;
    logic                  r_br_q,    w_br_d;
    logic                  r_busy_q,  w_busy_d;
    logic                  r_done_q,  w_done_d;
    logic                  r_bo_q,    w_bo_d;
    logic                  r_uf_q,    w_uf_d;

    // Operand registers shift right, so bit k is always at position 0.
    logic w_ak;
    logic w_bk;
    logic w_dk;
    logic w_br_next;

    assign w_ak      = r_a_q[0];
    assign w_bk      = r_b_q[0];
    assign w_dk      = w_ak ^ w_bk ^ r_br_q;
    assign w_br_next = (~w_ak & w_bk) | (~(w_ak ^ w_bk) & r_br_q);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_br_d    = r_br_q;
        w_diff_d  = r_diff_q;
        w_bo_d    = r_bo_q;
        w_uf_d    = r_uf_q;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_br_d    = borrow_in;
                    w_cnt_d   = '0;
                    w_res_d   = '0;
                    w_state_d = S_RUN;
                    w_busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                w_a_d   = r_a_q >> 1;
                w_b_d   = r_b_q >> 1;
                w_br_d  = w_br_next;
                w_res_d = {w_dk, r_res_q[BIT_WIDTH-1:1]};
                w_cnt_d = r_cnt_q + c_CNT_ONE;
                if (r_cnt_q == c_LAST_BIT) begin
                    // On the MSB step the current operand bits are the MSBs.
                    w_diff_d  = {w_dk, r_res_q[BIT_WIDTH-1:1]};
                    w_bo_d    = w_br_next;
                    w_uf_d    = (w_ak != w_bk) && (w_dk != w_ak);
                    w_state_d = S_DONE;
                    w_done_d  = 1'b1;
                end else begin
                    w_busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_br_q    <= 1'b0;
            r_diff_q  <= '0;
            r_bo_q    <= 1'b0;
            r_uf_q    <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_br_q    <= w_br_d;
            r_diff_q  <= w_diff_d;
            r_bo_q    <= w_bo_d;
            r_uf_q    <= w_uf_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy       = r_busy_q;
    assign done       = r_done_q;
    assign diff       = r_diff_q;
    assign borrow_out = r_bo_q;
    assign underflow  = r_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_serial_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_serial_16bit
// Description : Directed-vector bench for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_serial_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow_out;
    logic        underflow;

    int vec_cnt;
    int err_cnt;

    subtractor_serial_16bit #(.BIT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands at a falling edge; start is accepted on the next rising edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic bin);
        @(negedge clk);
        a         = av;
        b         = bv;
        borrow_in = bin;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Counts falling edges until done is seen (bounded); n_done=0 on timeout.
    task automatic wait_done(output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({busy, done, diff, borrow_out, underflow} !== 20'h0) begin
                $display("FAIL reset_hold: got busy=%b done=%b diff=%h bo=%b uf=%b, want all 0",
                         busy, done, diff, borrow_out, underflow);
                err_cnt++;
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({busy, done, diff, borrow_out, underflow} !== 20'h0) begin
                $display("FAIL reset_idle: got busy=%b done=%b diff=%h bo=%b uf=%b, want all 0",
                         busy, done, diff, borrow_out, underflow);
                err_cnt++;
            end
        end
    endtask

    task automatic test_basic;
        launch(16'h0005, 16'h0003, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== 16'h0000) begin
                $display("FAIL basic_run[%0d]: got busy=%b done=%b diff=%h, want 1 0 0000",
                         i, busy, done, diff);
                err_cnt++;
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b1 || diff !== 16'h0002 ||
            borrow_out !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL basic_done: got busy=%b done=%b diff=%h bo=%b uf=%b, want 0 1 0002 0 0",
                     busy, done, diff, borrow_out, underflow);
            err_cnt++;
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 16'h0002) begin
            $display("FAIL basic_after: got busy=%b done=%b diff=%h, want 0 0 0002",
                     busy, done, diff);
            err_cnt++;
        end
    endtask

    task automatic test_borrow;
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic        vi [2];
        logic [15:0] ed [2];
        logic        eb [2];
        logic        eu [2];
        int          nd;
        int          nb;
        va = '{16'h0000, 16'h0010};
        vb = '{16'h0001, 16'h0000};
        vi = '{1'b0, 1'b1};
        ed = '{16'hFFFF, 16'h000F};
        eb = '{1'b1, 1'b0};
        eu = '{1'b0, 1'b0};
        for (int k = 0; k < 2; k++) begin
            launch(va[k], vb[k], vi[k]);
            wait_done(nd, nb);
            vec_cnt++;
            if (nd !== 17 || nb !== 16 || diff !== ed[k] ||
                borrow_out !== eb[k] || underflow !== eu[k]) begin
                $display("FAIL borrow[%0d]: got cyc=%0d busy=%0d diff=%h bo=%b uf=%b, want 17 16 %h %b %b",
                         k, nd, nb, diff, borrow_out, underflow, ed[k], eb[k], eu[k]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [15:0] ed [2];
        logic        eb [2];
        int          nd;
        int          nb;
        va = '{16'h8000, 16'h7FFF};
        vb = '{16'h0001, 16'hFFFF};
        ed = '{16'h7FFF, 16'h8000};
        eb = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            launch(va[k], vb[k], 1'b0);
            wait_done(nd, nb);
            vec_cnt++;
            if (nd !== 17 || diff !== ed[k] || borrow_out !== eb[k] || underflow !== 1'b1) begin
                $display("FAIL overflow[%0d]: got cyc=%0d diff=%h bo=%b uf=%b, want 17 %h %b 1",
                         k, nd, diff, borrow_out, underflow, ed[k], eb[k]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_ignore_start;
        launch(16'h0005, 16'h0003, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== 16'h8000) begin
                $display("FAIL ignore_run[%0d]: got busy=%b done=%b diff=%h, want 1 0 8000",
                         i, busy, done, diff);
                err_cnt++;
            end
            if (i == 2) begin
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'h0000;
            end
            if (i == 5) begin
                start = 1'b0;
                a     = 16'hAAAA;
                b     = 16'h5555;
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b1 || diff !== 16'h0002 || borrow_out !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL ignore_done: got done=%b diff=%h bo=%b uf=%b, want 1 0002 0 0",
                     done, diff, borrow_out, underflow);
            err_cnt++;
        end
        // start held only across the DONE cycle must not launch anything
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0002) begin
                $display("FAIL ignore_after[%0d]: got busy=%b done=%b diff=%h, want 0 0 0002",
                         i, busy, done, diff);
                err_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        int nb;
        int n_pulses;
        launch(16'hFFFF, 16'h0001, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, done, diff, borrow_out, underflow} !== 20'h0) begin
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bo=%b uf=%b, want all 0",
                     busy, done, diff, borrow_out, underflow);
            err_cnt++;
        end
        n_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_pulses++;
        end
        vec_cnt++;
        if (n_pulses !== 0) begin
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles, want 0", n_pulses);
            err_cnt++;
        end
        launch(16'h1234, 16'h0234, 1'b0);
        wait_done(nd, nb);
        vec_cnt++;
        if (nd !== 17 || nb !== 16 || diff !== 16'h1000 ||
            borrow_out !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL reset_fresh: got cyc=%0d busy=%0d diff=%h bo=%b uf=%b, want 17 16 1000 0 0",
                     nd, nb, diff, borrow_out, underflow);
            err_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int nd;
        int nb;
        launch(16'h0100, 16'h0001, 1'b0);
        wait_done(nd, nb);
        vec_cnt++;
        if (nd !== 17 || diff !== 16'h00FF || borrow_out !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL b2b_first: got cyc=%0d diff=%h bo=%b uf=%b, want 17 00FF 0 0",
                     nd, diff, borrow_out, underflow);
            err_cnt++;
        end
        // earliest legal restart: the edge right after the DONE cycle
        launch(16'h0001, 16'h0002, 1'b1);
        wait_done(nd, nb);
        vec_cnt++;
        if (nd !== 17 || nb !== 16 || diff !== 16'hFFFE ||
            borrow_out !== 1'b1 || underflow !== 1'b0) begin
            $display("FAIL b2b_second: got cyc=%0d busy=%0d diff=%h bo=%b uf=%b, want 17 16 FFFE 1 0",
                     nd, nb, diff, borrow_out, underflow);
            err_cnt++;
        end
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
